// File: rtl/alu_pkg.sv
// Shared ALU definitions: bit-count mode encodings and an elaboration-time log2 helper.
package alu_pkg;

  localparam logic [1:0] ALU_BC_POP = 2'd0;
  localparam logic [1:0] ALU_BC_CLZ = 2'd1;
  localparam logic [1:0] ALU_BC_CTZ = 2'd2;
  localparam logic [1:0] ALU_BC_PAR = 2'd3;

  // Ceiling log2, used to size the count tree and result field from WIDTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_bitcnt_level.sv
// One registered level of the bit-count adder tree: adds adjacent pairs of
// IN_W-bit partial sums into (IN_W+1)-bit sums.
module alu_bitcnt_level
  import alu_pkg::*;
#(
  parameter int IN_W = 1,
  parameter int N    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N*IN_W-1:0]            in_sums,
  output logic [(N/2)*(IN_W+1)-1:0]    out_sums
);

  localparam int OW = IN_W + 1;
  localparam int NO = N / 2;

  logic [NO*OW-1:0] sums_d;

  // Pairwise zero-extended addition; the extra bit means no sum can overflow.
  always_comb begin
    sums_d = '0;
    for (int i = 0; i < NO; i++) begin
      sums_d[i*OW +: OW] = {1'b0, in_sums[(2*i)*IN_W +: IN_W]}
                         + {1'b0, in_sums[(2*i+1)*IN_W +: IN_W]};
    end
  end

  // Register the level; it advances only with the global pipeline enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sums <= '0;
    end else if (en) begin
      out_sums <= sums_d;
    end
  end

endmodule

// File: rtl/alu_bitcnt_pipe.sv
// Pipelined bit-count unit (POP/CLZ/CTZ/PAR). Stage 0 turns CLZ/CTZ into a
// population count of a smeared operand, then one adder-tree level is
// registered per cycle, followed by a result register. A single global
// enable stalls the whole pipe under backpressure.
module alu_bitcnt_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [clog2(WIDTH):0]   out_count,
  output logic                    out_zero,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int L = clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] smear_r;
  logic [WIDTH-1:0] smear_l;
  logic [WIDTH-1:0] v_d;
  logic [WIDTH-1:0] v_q;
  logic [L:0]       tree_sum;

  logic             valid_q [0:L];
  logic [1:0]       mode_q  [0:L];
  logic             zero_q  [0:L];
  logic [TAG_W-1:0] tag_q   [0:L];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Smear the operand toward the LSB and toward the MSB by doubling shifts.
  always_comb begin
    smear_r = in_data;
    smear_l = in_data;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      smear_r = smear_r | (smear_r >> s);
      smear_l = smear_l | (smear_l << s);
    end
  end

  // Pick the vector whose population count gives the requested result.
  always_comb begin
    v_d = in_data;
    case (in_mode)
      ALU_BC_CLZ: v_d = ~smear_r;
      ALU_BC_CTZ: v_d = ~smear_l;
      default:    v_d = in_data;
    endcase
  end

  // Stage 0 operand register feeding the tree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= v_d;
    end
  end

  // Sideband shift register keeping valid/mode/zero/tag aligned with the tree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= L; i++) begin
        valid_q[i] <= 1'b0;
        mode_q[i]  <= 2'd0;
        zero_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      mode_q[0]  <= in_mode;
      zero_q[0]  <= (in_data == '0);
      tag_q[0]   <= in_tag;
      for (int i = 1; i <= L; i++) begin
        valid_q[i] <= valid_q[i-1];
        mode_q[i]  <= mode_q[i-1];
        zero_q[i]  <= zero_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int IW = k + 1;
    localparam int NS = WIDTH >> k;
    logic [(NS/2)*(IW+1)-1:0] sums;
    if (k == 0) begin : g_first
      alu_bitcnt_level #(.IN_W(IW), .N(NS)) u_level (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_sums  (v_q),
        .out_sums (sums)
      );
    end else begin : g_rest
      alu_bitcnt_level #(.IN_W(IW), .N(NS)) u_level (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_sums  (g_lvl[k-1].sums),
        .out_sums (sums)
      );
    end
  end

  assign tree_sum = g_lvl[L-1].sums;

  // Result register: parity keeps only the LSB of the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= valid_q[L];
      out_count <= (mode_q[L] == ALU_BC_PAR) ? {{L{1'b0}}, tree_sum[0]} : tree_sum;
      out_zero  <= zero_q[L];
      out_tag   <= tag_q[L];
    end
  end

endmodule
